// File: rtl/serial_2scomp_mc_pkg.sv
// Shared types for the multi-channel serial two's-complement unit:
// the operating-mode encoding and the output-sequencer state.
package serial_2sc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_RUN  = 1'b1
  } out_state_t;

endpackage

// File: rtl/serial_2scomp_mc_if.sv
// Serial stream bundle: word-framed input bits per lane plus framed result bits.
// master = stream source/consumer side, slave = the processing unit.
interface serial_2scomp_mc_if #(
  parameter int unsigned CHANNELS = 2
);

  logic                start;
  logic [CHANNELS-1:0] data;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] pout;
  logic                pvalid;
  logic                pfirst;
  logic                plast;
  logic [CHANNELS-1:0] overflow;

  modport master (
    output start, data, mode,
    input  pout, pvalid, pfirst, plast, overflow
  );

  modport slave (
    input  start, data, mode,
    output pout, pvalid, pfirst, plast, overflow
  );

endinterface

// File: rtl/serial_2scomp_mc_lane.sv
// One lane: input word buffer, serial negator with seen_one, sign-driven enable.
// Most-negative overflow detection is compiled in only with SERIAL_2SC_OVF_EN.
module serial_2sc_lane
  import serial_2sc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  sample,
  input  logic  load,
  input  logic  shift,
  input  logic  last,
  input  logic  din,
  input  mode_t mode_q,
  output logic  pout,
  output logic  overflow
);

  logic [WIDTH-2:0] in_sr;
  logic [WIDTH-2:0] out_sr;
  logic [WIDTH-1:0] word;
  logic             seen_one;
  logic             neg_en;
  logic             neg_next;

  assign word = {din, in_sr};

  always_comb begin
    neg_next = (mode_q == MODE_NEG) | ((mode_q == MODE_ABS) & din);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_sr <= '0;
    end else if (sample) begin
      in_sr <= word[WIDTH-1:1];
    end
  end

  // Bit 0 leaves on the load edge itself, so the shift register keeps only bits 1..WIDTH-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_sr   <= '0;
      pout     <= 1'b0;
      seen_one <= 1'b0;
      neg_en   <= 1'b0;
    end else if (load) begin
      out_sr   <= word[WIDTH-1:1];
      pout     <= word[0];
      seen_one <= word[0];
      neg_en   <= neg_next;
    end else if (shift) begin
      out_sr   <= out_sr >> 1;
      pout     <= out_sr[0] ^ (neg_en & seen_one);
      seen_one <= seen_one | out_sr[0];
    end else begin
      pout     <= 1'b0;
    end
  end

`ifdef SERIAL_2SC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      ovf_q    <= neg_next & din & (in_sr == '0);
      overflow <= 1'b0;
    end else if (shift) begin
      overflow <= last & ovf_q;
    end else begin
      overflow <= 1'b0;
    end
  end
`else
  logic last_unused;

  assign last_unused = last;
  assign overflow    = 1'b0;
`endif

endmodule

// File: rtl/serial_2scomp_mc.sv
// Multi-channel framed serial two's-complement unit (pass / negate / abs).
// Define SERIAL_2SC_OVF_EN to enable per-lane most-negative overflow flags.
module serial_2scomp_mc
  import serial_2sc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
) (
  input logic               clk,
  input logic               reset_n,
  serial_2scomp_mc_if.slave bus
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       ocnt;
  logic [CW-1:0]       ocnt_next;
  mode_t               mode_q;
  out_state_t          state;
  out_state_t          state_next;
  logic                load;
  logic                shift;
  logic                last;
  logic [CHANNELS-1:0] pout_w;
  logic [CHANNELS-1:0] ovf_w;

  assign load = bus.start && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      mode_q <= MODE_PASS;
    end else begin
      if (!bus.start || cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (bus.start && cnt == '0) begin
        mode_q <= mode_t'(bus.mode);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OUT_IDLE;
      ocnt  <= '0;
    end else begin
      state <= state_next;
      ocnt  <= ocnt_next;
    end
  end

  // A load restarts the output word even while the previous one shows its last bit.
  always_comb begin
    state_next = state;
    ocnt_next  = ocnt;
    shift      = 1'b0;
    last       = 1'b0;
    if (load) begin
      state_next = OUT_RUN;
      ocnt_next  = '0;
    end else if (state == OUT_RUN) begin
      if (ocnt == LAST) begin
        state_next = OUT_IDLE;
      end else begin
        shift     = 1'b1;
        ocnt_next = ocnt + 1'b1;
        last      = (ocnt_next == LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.pvalid <= 1'b0;
      bus.pfirst <= 1'b0;
      bus.plast  <= 1'b0;
    end else begin
      bus.pvalid <= load | shift;
      bus.pfirst <= load;
      bus.plast  <= last;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    serial_2sc_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .sample  (bus.start),
      .load    (load),
      .shift   (shift),
      .last    (last),
      .din     (bus.data[g]),
      .mode_q  (mode_q),
      .pout    (pout_w[g]),
      .overflow(ovf_w[g])
    );
  end

  assign bus.pout     = pout_w;
  assign bus.overflow = ovf_w;

endmodule

// File: tb/tb_serial_2scomp_mc.sv
// Directed bench for serial_2scomp_mc (WIDTH=8, CHANNELS=2): vector table plus
// streaming, aborted-word and asynchronous-reset sequences.
module tb_serial_2scomp_mc;

`ifdef SERIAL_2SC_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;

  serial_2scomp_mc_if #(.CHANNELS(2)) bus ();

  serial_2scomp_mc #(
    .WIDTH   (8),
    .CHANNELS(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] mode_mid;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] eo;
  } vec_t;

  vec_t vecs[6];

  int tests = 0;
  int fails = 0;

  int         cyc;
  int         nbits;
  logic [7:0] acc0, acc1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [1:0] qo[$];
  int         frame_err, stray, vcount, run, maxrun, pf_after_pl, pfirst_cyc;
  logic       pl_prev;
  int         start_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    nbits = 0; acc0 = '0; acc1 = '0;
    q0.delete(); q1.delete(); qo.delete();
    frame_err = 0; stray = 0; vcount = 0; run = 0; maxrun = 0;
    pf_after_pl = 0; pfirst_cyc = -1; pl_prev = 1'b0;
  endtask

  task automatic sample_out();
    if (bus.pvalid) begin
      vcount++; run++;
      if (run > maxrun) maxrun = run;
      if (bus.pfirst) begin
        nbits = 0;
        if (pfirst_cyc < 0) pfirst_cyc = cyc;
        if (pl_prev) pf_after_pl++;
      end
      if (nbits < 8) begin
        acc0[nbits] = bus.pout[0];
        acc1[nbits] = bus.pout[1];
      end
      if (!bus.plast && bus.overflow != 2'b00) stray++;
      if (bus.plast) begin
        if (nbits != 7) frame_err++;
        q0.push_back(acc0);
        q1.push_back(acc1);
        qo.push_back(bus.overflow);
      end
      nbits++;
    end else begin
      run = 0;
      if (bus.pfirst || bus.plast || bus.overflow != 2'b00) stray++;
    end
    pl_prev = bus.pvalid && bus.plast;
  endtask

  task automatic step(input logic s, input logic [1:0] d, input logic [1:0] m);
    bus.start = s;
    bus.data  = d;
    bus.mode  = m;
    @(posedge clk);
    #1;
    cyc++;
    sample_out();
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [1:0] m, input logic [1:0] m_mid);
    logic [7:0] a, b;
    a = w0; b = w1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {b[i], a[i]}, (i >= 3) ? m_mid : m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00);
  endtask

  function automatic logic [7:0] qget(input int which, input int idx);
    logic [7:0] r;
    r = 8'hxx;
    if (which == 0 && q0.size() > idx) r = q0[idx];
    if (which == 1 && q1.size() > idx) r = q1[idx];
    if (which == 2 && qo.size() > idx) r = {6'b0, qo[idx]};
    return r;
  endfunction

  initial begin
    vecs[0] = '{mode: 2'b01, mode_mid: 2'b01, w0: 8'h05, w1: 8'h00, e0: 8'hFB, e1: 8'h00, eo: 2'b00};
    vecs[1] = '{mode: 2'b10, mode_mid: 2'b00, w0: 8'hF6, w1: 8'h0A, e0: 8'h0A, e1: 8'h0A, eo: 2'b00};
    vecs[2] = '{mode: 2'b01, mode_mid: 2'b01, w0: 8'h80, w1: 8'h7F, e0: 8'h80, e1: 8'h81, eo: 2'b01};
    vecs[3] = '{mode: 2'b00, mode_mid: 2'b01, w0: 8'h80, w1: 8'hA5, e0: 8'h80, e1: 8'hA5, eo: 2'b00};
    vecs[4] = '{mode: 2'b11, mode_mid: 2'b01, w0: 8'h3C, w1: 8'hC3, e0: 8'h3C, e1: 8'hC3, eo: 2'b00};
    vecs[5] = '{mode: 2'b10, mode_mid: 2'b10, w0: 8'h80, w1: 8'h01, e0: 8'h80, e1: 8'h01, eo: 2'b01};

    cyc = 0;
    clear_mon();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.data  = 2'b00;
    bus.mode  = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", {27'b0, bus.pout, bus.pvalid, bus.pfirst, bus.plast},
          {27'b0, 2'b00, 3'b000});
    check("reset_ovf", {30'b0, bus.overflow}, 32'h0);
    reset_n = 1'b1;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      start_cyc = cyc + 1;
      send_word(vecs[v].w0, vecs[v].w1, vecs[v].mode, vecs[v].mode_mid);
      idle(10);
      check($sformatf("v%0d_words", v), q0.size(), 1);
      check($sformatf("v%0d_lane0", v), qget(0, 0), vecs[v].e0);
      check($sformatf("v%0d_lane1", v), qget(1, 0), vecs[v].e1);
      check($sformatf("v%0d_ovf", v), qget(2, 0), {6'b0, vecs[v].eo & {2{OVF_ON}}});
      check($sformatf("v%0d_latency", v), pfirst_cyc - start_cyc, 7);
      check($sformatf("v%0d_framing", v), frame_err + stray, 0);
    end

    // Three back-to-back words with start held high.
    clear_mon();
    send_word(8'h01, 8'h02, 2'b01, 2'b01);
    send_word(8'h7F, 8'h80, 2'b01, 2'b01);
    send_word(8'h00, 8'h10, 2'b01, 2'b01);
    idle(10);
    check("stream_valid_run", maxrun, 24);
    check("stream_valid_count", vcount, 24);
    check("stream_pfirst_after_plast", pf_after_pl, 2);
    check("stream_words", q0.size(), 3);
    check("stream_w0_l0", qget(0, 0), 8'hFF);
    check("stream_w1_l0", qget(0, 1), 8'h81);
    check("stream_w2_l0", qget(0, 2), 8'h00);
    check("stream_w0_l1", qget(1, 0), 8'hFE);
    check("stream_w1_l1", qget(1, 1), 8'h80);
    check("stream_w2_l1", qget(1, 2), 8'hF0);
    check("stream_ovf", {qget(2, 0), qget(2, 1), qget(2, 2)},
          {8'h00, 6'b0, 2'b10 & {2{OVF_ON}}, 8'h00});
    check("stream_framing", frame_err + stray, 0);

    // Word aborted after three bits, then a clean pass-mode word.
    clear_mon();
    step(1'b1, 2'b11, 2'b00);
    step(1'b1, 2'b11, 2'b00);
    step(1'b1, 2'b11, 2'b00);
    idle(10);
    check("abort_no_valid", vcount, 0);
    clear_mon();
    start_cyc = cyc + 1;
    send_word(8'h03, 8'h40, 2'b00, 2'b00);
    idle(10);
    check("abort_next_l0", qget(0, 0), 8'h03);
    check("abort_next_l1", qget(1, 0), 8'h40);
    check("abort_next_latency", pfirst_cyc - start_cyc, 7);

    // Reset asserted while output bit 4 is on the wire.
    clear_mon();
    send_word(8'h05, 8'h11, 2'b01, 2'b01);
    for (int k = 0; k < 20 && nbits != 5; k++) step(1'b0, 2'b00, 2'b00);
    check("rst_reached_bit4", nbits, 5);
    check("rst_before_valid", {31'b0, bus.pvalid}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_outs", {27'b0, bus.pout, bus.pvalid, bus.pfirst, bus.plast}, 32'h0);
    check("rst_async_ovf", {30'b0, bus.overflow}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_mon();
    start_cyc = cyc + 1;
    send_word(8'h80, 8'h05, 2'b01, 2'b01);
    idle(10);
    check("rst_fresh_l0", qget(0, 0), 8'h80);
    check("rst_fresh_l1", qget(1, 0), 8'hFB);
    check("rst_fresh_ovf", qget(2, 0), {6'b0, 2'b01 & {2{OVF_ON}}});
    check("rst_fresh_latency", pfirst_cyc - start_cyc, 7);
    check("rst_fresh_words", q0.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_2scomp_mc.md
# serial_2scomp_mc

Multi-channel, word-framed, bit-serial two's-complement unit. Each lane accepts an LSB-first serial word and emits it LSB-first in one of three modes:
- pass-through
- negate
- absolute value

All lanes run in lock-step from one frame counter. A one-word buffer per lane makes the sign bit available before output starts, which is what enables absolute-value mode and overflow detection. The block sits between serial data sources and downstream serial consumers. It replaces the single-channel, unframed negator.

## Interface
Parameters:
- WIDTH, 8, word length in bits (≥2)
- CHANNELS, 2, number of parallel lanes (≥1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  level enable; each clk edge with start=1 samples one bit per lane
- data  input  CHANNELS  serial input bit per lane, LSB first
- mode  input  2  00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass)
- pout  output  CHANNELS  serial result bit per lane, LSB first
- pvalid  output  1  pout carries a valid bit
- pfirst  output  1  pout carries bit 0 of a word
- plast  output  1  pout carries bit WIDTH-1 of a word
- overflow  output  CHANNELS  per-lane overflow, meaningful only while plast=1

## Operation
- **Shared bit counter** `cnt`, range 0..WIDTH-1:
  - Increments on every edge with start=1; wraps WIDTH-1→0.
  - start=0 forces cnt←0 and discards any partial input word.
- **Mode capture:** mode is latched into `mode_q` on the edge where cnt==0 and start=1. Changes of mode mid-word are ignored.
- **Input side (per lane):** WIDTH-1-bit input shift register collects bits 0..WIDTH-2.
- **Transfer edge** (start=1, cnt==WIDTH-1), per lane:
  - Full word {data, in_sr} loads into the output shift register.
  - sign = data (the MSB).
  - neg_en = (mode_q==01) | (mode_q==10 & sign).
- **Output side (per lane):** serial negator with a `seen_one` flag.
  - Out bit = in bit XOR (neg_en & seen_one).
  - seen_one is cleared at word start and set after the first 1 bit is emitted.
- **Overflow:** set when neg_en=1 and the word is 1000…0 (most negative). The result equals the input in that case. Pass mode never overflows.
- **Output sequencing:** output counter runs 0..WIDTH-1 after each transfer.
  - pvalid=1 for WIDTH cycles.
  - pfirst=1 at output bit 0; plast=1 at output bit WIDTH-1.
- **Streaming:** input and output sides are independent (double buffer). A transfer that coincides with output bit WIDTH-1 continues without a gap: pvalid stays high and pfirst follows plast directly.
- **start drop mid-word:** affects only the input side. A word already transferred always completes its output.
- **Reset:** asynchronous. Mid-operation it aborts both sides immediately.

## Timing
- Reset values: pout=0, pvalid=0, pfirst=0, plast=0, overflow=0, cnt=0, all shift registers and flags 0, mode_q=00.
- All outputs are registered.
- Latency: input bit i is sampled at edge E_i. The corresponding output bit is valid in the cycle following edge E_i+(WIDTH-1). Output bit 0 is driven by the transfer edge itself.
- Throughput: one bit per lane per cycle, sustained indefinitely with start held high.
- overflow is valid in the plast cycle and is 0 in all other cycles.

## Configuration
- SERIAL_2SC_OVF_EN defined:
  - 1000…0 detection logic is compiled in.
  - overflow behaves as specified above.
- SERIAL_2SC_OVF_EN undefined:
  - Detection logic is removed.
  - overflow ports remain and are tied to 0.
  - All other behaviour is unchanged.

## Structure
- Package serial_2sc_pkg holds:
  - mode constants MODE_PASS=2'b00, MODE_NEG=2'b01, MODE_ABS=2'b10
  - the 2-bit mode typedef
- Sub-module serial_2sc_lane:
  - One instance per channel via a generate loop.
  - Contains the input/output shift registers, sign capture, seen_one, neg_en and overflow logic.
- Top level holds:
  - shared cnt and output counter
  - mode_q
  - pvalid/pfirst/plast generation

## Test plan
All scenarios use WIDTH=8, CHANNELS=2 unless stated.
- **Negate:** mode=01, lane0 word 0x05 (bits 1,0,1,0,0,0,0,0) → pout 1,1,0,1,1,1,1,1 (0xFB); pfirst on first bit, plast on eighth; overflow=0.
- **Absolute value:** mode=10, lane0 0xF6, lane1 0x0A → both lanes output 0x0A; mode changed to 00 mid-word → still absolute value for that word.
- **Overflow:** mode=01, word 0x80 → output 0x80, overflow=1 with plast when SERIAL_2SC_OVF_EN is defined; overflow=0 throughout when undefined.
- **Streaming:** start held high for three back-to-back words 0x01, 0x7F, 0x00 in negate mode → pvalid continuous for 24 cycles; outputs 0xFF, 0x81, 0x00; pfirst immediately after each plast.
- **Aborted word:** start dropped after 3 bits → no transfer and pvalid stays 0; next full word 0x03 in pass mode → 0x03 emitted correctly.
- **Reset mid-output:** reset_n asserted during output bit 4 → all outputs 0 asynchronously; after release, a fresh word produces correct output with nominal latency.
